// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control unit: FSM state
// encoding, opcode constants and the datapath mux/ALU/immediate encodings.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEMADR    = 4'd2,
        ST_MEMREAD   = 4'd3,
        ST_MEMWB     = 4'd4,
        ST_MEMWRITE  = 4'd5,
        ST_EXECR     = 4'd6,
        ST_EXECI     = 4'd7,
        ST_ALUWB     = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_JAL       = 4'd10,
        ST_JALR      = 4'd11,
        ST_JALR_LINK = 4'd12,
        ST_LUI       = 4'd13,
        ST_AUIPC     = 4'd14,
        ST_TRAP      = 4'd15
    } ctrl_state_t;

    // Opcodes recognised by the decoder
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // result_src encodings
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // alu_src_a encodings
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    // alu_src_b encodings
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // alu_op encodings
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    // imm_src encodings
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // True for every opcode the decoder has a sequence for
    function automatic logic is_known_op(input logic [6:0] op_v);
        logic known_v;
        case (op_v)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: known_v = 1'b1;
            default:                           known_v = 1'b0;
        endcase
        return known_v;
    endfunction

endpackage

// File: rtl/imm_src_decode.sv
// Combinational opcode -> immediate-format select for the immediate extender.
module imm_src_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [2:0] imm_src
);

    // Pick the immediate layout implied by the opcode; unknown opcodes use I
    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_STORE:         imm_src = IMM_S;
            OP_BRANCH:        imm_src = IMM_B;
            OP_JAL:           imm_src = IMM_J;
            OP_LUI, OP_AUIPC: imm_src = IMM_U;
            default:          imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: Moore FSM sequencing each instruction over
// one shared ALU and a unified memory with a mem_req/mem_ready handshake,
// plus a memory-timeout watchdog, an absorbing trap state and a retired-
// instruction counter.
// Optional feature macro: ILLEGAL_TRAP_EN (unknown opcodes trap instead of
// being skipped as a NOP).
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             pc_update,
    output logic             branch,
    output logic             adr_src,
    output logic             mem_write,
    output logic             ir_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [2:0]       imm_src,
    output logic             reg_write,
    output logic             trap,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] instret
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    ctrl_state_t      state_r;
    ctrl_state_t      state_next_s;
    logic [7:0]       wdog_r;
    logic [7:0]       wdog_next_s;
    logic             waiting_s;
    logic             timeout_s;
    logic             retire_s;
    logic [CNT_W-1:0] instret_r;
    logic             bus_err_r;

    imm_src_decode u_imm_src_decode (
        .op      (op),
        .imm_src (imm_src)
    );

    // Flag a cycle spent waiting on memory in any state that issues a request
    always_comb begin
        waiting_s = 1'b0;
        case (state_r)
            ST_FETCH, ST_MEMREAD, ST_MEMWRITE: waiting_s = ~mem_ready;
            default:                           waiting_s = 1'b0;
        endcase
    end

    // Watchdog fires on the wait cycle that brings the count to TIMEOUT;
    // mem_ready in that cycle means no wait, so the access completes instead
    always_comb begin
        timeout_s = waiting_s & ((wdog_r + 8'd1) == TIMEOUT_C);
        if (waiting_s && !timeout_s) begin
            wdog_next_s = wdog_r + 8'd1;
        end else begin
            wdog_next_s = 8'd0;
        end
    end

    // Final cycle of an instruction, where it is counted as retired
    always_comb begin
        retire_s = 1'b0;
        case (state_r)
            ST_ALUWB, ST_MEMWB, ST_BRANCH: retire_s = 1'b1;
            ST_MEMWRITE:                   retire_s = mem_ready;
            default:                       retire_s = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a watchdog expiry overrides the normal sequence
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (mem_ready) begin
                    state_next_s = ST_DECODE;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_next_s = ST_MEMADR;
                    OP_RTYPE:          state_next_s = ST_EXECR;
                    OP_ITYPE:          state_next_s = ST_EXECI;
                    OP_BRANCH:         state_next_s = ST_BRANCH;
                    OP_JAL:            state_next_s = ST_JAL;
                    OP_JALR:           state_next_s = ST_JALR;
                    OP_LUI:            state_next_s = ST_LUI;
                    OP_AUIPC:          state_next_s = ST_AUIPC;
`ifdef ILLEGAL_TRAP_EN
                    default:           state_next_s = ST_TRAP;
`else
                    default:           state_next_s = ST_FETCH;
`endif
                endcase
            end
            ST_MEMADR: begin
                if (op == OP_LOAD) begin
                    state_next_s = ST_MEMREAD;
                end else begin
                    state_next_s = ST_MEMWRITE;
                end
            end
            ST_MEMREAD: begin
                if (mem_ready) begin
                    state_next_s = ST_MEMWB;
                end else begin
                    state_next_s = ST_MEMREAD;
                end
            end
            ST_MEMWRITE: begin
                if (mem_ready) begin
                    state_next_s = ST_FETCH;
                end else begin
                    state_next_s = ST_MEMWRITE;
                end
            end
            ST_MEMWB:      state_next_s = ST_FETCH;
            ST_EXECR:      state_next_s = ST_ALUWB;
            ST_EXECI:      state_next_s = ST_ALUWB;
            ST_ALUWB:      state_next_s = ST_FETCH;
            ST_BRANCH:     state_next_s = ST_FETCH;
            ST_JAL:        state_next_s = ST_ALUWB;
            ST_JALR:       state_next_s = ST_JALR_LINK;
            ST_JALR_LINK:  state_next_s = ST_ALUWB;
            ST_LUI:        state_next_s = ST_ALUWB;
            ST_AUIPC:      state_next_s = ST_ALUWB;
            ST_TRAP:       state_next_s = ST_TRAP;
            default:       state_next_s = ST_TRAP;
        endcase
        if (timeout_s) begin
            state_next_s = ST_TRAP;
        end else begin
            state_next_s = state_next_s;
        end
    end

    // Datapath controls decoded from the registered state
    always_comb begin
        mem_req    = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_ADD;
        reg_write  = 1'b0;
        trap       = 1'b0;
        case (state_r)
            ST_FETCH: begin
                mem_req    = 1'b1;
                adr_src    = 1'b0;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                alu_op     = ALUOP_ADD;
                result_src = RES_ALURESULT;
                ir_write   = mem_ready;
                pc_update  = mem_ready;
            end
            ST_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
            end
            ST_MEMADR, ST_JALR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
            end
            ST_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            ST_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
            end
            ST_MEMWRITE: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            ST_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op    = ALUOP_FUNCT;
            end
            ST_EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_op     = ALUOP_BRANCH;
                result_src = RES_ALUOUT;
                branch     = 1'b1;
            end
            ST_JAL, ST_JALR_LINK: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALUOUT;
                pc_update  = 1'b1;
            end
            ST_LUI: begin
                alu_src_a = SRCA_ZERO;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
            end
            ST_AUIPC: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
            end
            ST_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                trap = 1'b1;
            end
        endcase
    end

    // Memory-wait watchdog counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            wdog_r <= 8'd0;
        end else begin
            wdog_r <= wdog_next_s;
        end
    end

    // Retired-instruction counter, wrapping at 2^CNT_W
    always_ff @(posedge clk) begin
        if (!reset) begin
            instret_r <= {CNT_W{1'b0}};
        end else if (retire_s) begin
            instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            instret_r <= instret_r;
        end
    end

    // Sticky bus-error cause, set when the watchdog sends the FSM to TRAP
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus_err_r <= 1'b0;
        end else if (timeout_s) begin
            bus_err_r <= 1'b1;
        end else begin
            bus_err_r <= bus_err_r;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_r;

    // Sticky illegal-opcode cause, set when DECODE sees an unknown opcode
    always_ff @(posedge clk) begin
        if (!reset) begin
            illegal_r <= 1'b0;
        end else if ((state_r == ST_DECODE) && !is_known_op(op)) begin
            illegal_r <= 1'b1;
        end else begin
            illegal_r <= illegal_r;
        end
    end

    assign illegal = illegal_r;
`else
    assign illegal = 1'b0;
`endif

    assign instret = instret_r;
    assign bus_err = bus_err_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller (TIMEOUT=4).
module tb_multicycle_controller;
    import riscv_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic [6:0]  op;
    logic        mem_ready;
    logic        mem_req, pc_update, branch, adr_src, mem_write, ir_write;
    logic [1:0]  result_src, alu_src_a, alu_src_b, alu_op;
    logic [2:0]  imm_src;
    logic        reg_write, trap, illegal, bus_err;
    logic [31:0] instret;
    logic [15:0] outs;

    int checks   = 0;
    int failures = 0;

    multicycle_controller #(.TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .mem_req(mem_req), .pc_update(pc_update), .branch(branch),
        .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .imm_src(imm_src), .reg_write(reg_write),
        .trap(trap), .illegal(illegal), .bus_err(bus_err), .instret(instret)
    );

    // {mem_req, pc_update, branch, adr_src, mem_write, ir_write,
    //  result_src, alu_src_a, alu_src_b, alu_op, reg_write, trap}
    assign outs = {mem_req, pc_update, branch, adr_src, mem_write, ir_write,
                   result_src, alu_src_a, alu_src_b, alu_op, reg_write, trap};

    localparam logic [15:0] E_FETCH_W  = {6'b100000, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00};
    localparam logic [15:0] E_FETCH_R  = {6'b110001, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00};
    localparam logic [15:0] E_DECODE   = {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    localparam logic [15:0] E_MEMADR   = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00};
    localparam logic [15:0] E_MEMREAD  = {6'b100100, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [15:0] E_MEMWB    = {6'b000000, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
    localparam logic [15:0] E_MEMWRITE = {6'b100110, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [15:0] E_EXECR    = {6'b000000, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00};
    localparam logic [15:0] E_EXECI    = {6'b000000, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00};
    localparam logic [15:0] E_ALUWB    = {6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
    localparam logic [15:0] E_BRANCH   = {6'b001000, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    localparam logic [15:0] E_JAL      = {6'b010000, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
    localparam logic [15:0] E_LUI      = {6'b000000, 2'b00, 2'b11, 2'b01, 2'b00, 2'b00};
    localparam logic [15:0] E_AUIPC    = {6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    localparam logic [15:0] E_TRAP     = {6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive mem_ready, check the control bundle for this cycle, then advance
    task automatic cyc(input string tag, input logic rdy, input logic [15:0] exp);
        mem_ready = rdy;
        #1;
        chk(tag, {16'h0000, outs}, {16'h0000, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        op = 7'b0000000;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("reset_outs", {16'h0000, outs}, {16'h0000, E_FETCH_W});
        chk("reset_instret", instret, 32'd0);
        chk("reset_bus_err", {31'd0, bus_err}, 32'd0);
        chk("reset_illegal", {31'd0, illegal}, 32'd0);
        reset = 1'b1;

        // lw, zero wait states: 5 cycles
        op = OP_LOAD;
        #1 chk("lw_imm", {29'd0, imm_src}, {29'd0, IMM_I});
        cyc("lw_fetch",   1'b1, E_FETCH_R);
        cyc("lw_decode",  1'b1, E_DECODE);
        cyc("lw_memadr",  1'b1, E_MEMADR);
        cyc("lw_memread", 1'b1, E_MEMREAD);
        chk("lw_instret_before", instret, 32'd0);
        cyc("lw_memwb",   1'b1, E_MEMWB);
        chk("lw_instret_after", instret, 32'd1);

        // sw with 3 wait cycles in MEMWRITE; completes just before timeout
        op = OP_STORE;
        #1 chk("sw_imm", {29'd0, imm_src}, {29'd0, IMM_S});
        cyc("sw_fetch",  1'b1, E_FETCH_R);
        cyc("sw_decode", 1'b1, E_DECODE);
        cyc("sw_memadr", 1'b1, E_MEMADR);
        cyc("sw_wait1",  1'b0, E_MEMWRITE);
        cyc("sw_wait2",  1'b0, E_MEMWRITE);
        cyc("sw_wait3",  1'b0, E_MEMWRITE);
        chk("sw_instret_wait", instret, 32'd1);
        cyc("sw_done",   1'b1, E_MEMWRITE);
        cyc("sw_back_fetch", 1'b1, E_FETCH_R);
        chk("sw_bus_err", {31'd0, bus_err}, 32'd0);
        chk("sw_instret", instret, 32'd2);
        // the FETCH above consumed a fetch with op=store; finish that sw
        cyc("sw2_decode", 1'b1, E_DECODE);
        cyc("sw2_memadr", 1'b1, E_MEMADR);
        cyc("sw2_write",  1'b1, E_MEMWRITE);
        chk("sw2_instret", instret, 32'd3);

        // R-type
        op = OP_RTYPE;
        cyc("r_fetch",  1'b1, E_FETCH_R);
        cyc("r_decode", 1'b1, E_DECODE);
        cyc("r_execr",  1'b1, E_EXECR);
        cyc("r_aluwb",  1'b1, E_ALUWB);
        chk("r_instret", instret, 32'd4);

        // I-type with two FETCH wait cycles
        op = OP_ITYPE;
        cyc("i_fetch_w1", 1'b0, E_FETCH_W);
        cyc("i_fetch_w2", 1'b0, E_FETCH_W);
        cyc("i_fetch",    1'b1, E_FETCH_R);
        cyc("i_decode",   1'b1, E_DECODE);
        cyc("i_execi",    1'b1, E_EXECI);
        cyc("i_aluwb",    1'b1, E_ALUWB);
        chk("i_instret", instret, 32'd5);

        // beq: 3 cycles
        op = OP_BRANCH;
        #1 chk("beq_imm", {29'd0, imm_src}, {29'd0, IMM_B});
        cyc("beq_fetch",  1'b1, E_FETCH_R);
        cyc("beq_decode", 1'b1, E_DECODE);
        cyc("beq_branch", 1'b1, E_BRANCH);
        chk("beq_instret", instret, 32'd6);

        // jal: 4 cycles
        op = OP_JAL;
        #1 chk("jal_imm", {29'd0, imm_src}, {29'd0, IMM_J});
        cyc("jal_fetch",  1'b1, E_FETCH_R);
        cyc("jal_decode", 1'b1, E_DECODE);
        cyc("jal_jal",    1'b1, E_JAL);
        cyc("jal_aluwb",  1'b1, E_ALUWB);
        chk("jal_instret", instret, 32'd7);

        // jalr: 5 cycles, pc_update only in JALR_LINK
        op = OP_JALR;
        cyc("jalr_fetch",  1'b1, E_FETCH_R);
        cyc("jalr_decode", 1'b1, E_DECODE);
        cyc("jalr_target", 1'b1, E_MEMADR);
        cyc("jalr_link",   1'b1, E_JAL);
        cyc("jalr_aluwb",  1'b1, E_ALUWB);
        chk("jalr_instret", instret, 32'd8);

        // lui / auipc
        op = OP_LUI;
        #1 chk("lui_imm", {29'd0, imm_src}, {29'd0, IMM_U});
        cyc("lui_fetch",  1'b1, E_FETCH_R);
        cyc("lui_decode", 1'b1, E_DECODE);
        cyc("lui_lui",    1'b1, E_LUI);
        cyc("lui_aluwb",  1'b1, E_ALUWB);
        op = OP_AUIPC;
        cyc("auipc_fetch",  1'b1, E_FETCH_R);
        cyc("auipc_decode", 1'b1, E_DECODE);
        cyc("auipc_auipc",  1'b1, E_AUIPC);
        cyc("auipc_aluwb",  1'b1, E_ALUWB);
        chk("auipc_instret", instret, 32'd10);

        // reset asserted while in MEMREAD aborts the load
        op = OP_LOAD;
        cyc("rst_fetch",  1'b1, E_FETCH_R);
        cyc("rst_decode", 1'b1, E_DECODE);
        cyc("rst_memadr", 1'b1, E_MEMADR);
        mem_ready = 1'b0;
        #1 chk("rst_memread", {16'h0000, outs}, {16'h0000, E_MEMREAD});
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_fetch_after", {16'h0000, outs}, {16'h0000, E_FETCH_W});
        chk("rst_instret", instret, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;

        // unknown opcode 0000000
        op = 7'b0000000;
        #1 chk("ill_imm", {29'd0, imm_src}, {29'd0, IMM_I});
        cyc("ill_fetch",  1'b1, E_FETCH_R);
        cyc("ill_decode", 1'b1, E_DECODE);
`ifdef ILLEGAL_TRAP_EN
        chk("ill_trap", {16'h0000, outs}, {16'h0000, E_TRAP});
        chk("ill_illegal", {31'd0, illegal}, 32'd1);
        chk("ill_bus_err", {31'd0, bus_err}, 32'd0);
`else
        chk("ill_nop_fetch", {16'h0000, outs}, {16'h0000, E_FETCH_R});
        chk("ill_illegal", {31'd0, illegal}, 32'd0);
`endif
        chk("ill_instret", instret, 32'd0);

        // FETCH starved of mem_ready: TRAP after 4 wait cycles, then absorbing
        do_reset();
        op = OP_RTYPE;
        cyc("to_wait1", 1'b0, E_FETCH_W);
        cyc("to_wait2", 1'b0, E_FETCH_W);
        cyc("to_wait3", 1'b0, E_FETCH_W);
        cyc("to_wait4", 1'b0, E_FETCH_W);
        chk("to_trap", {16'h0000, outs}, {16'h0000, E_TRAP});
        chk("to_bus_err", {31'd0, bus_err}, 32'd1);
        chk("to_illegal", {31'd0, illegal}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            cyc("to_stay_trap", i[0], E_TRAP);
        end
        chk("to_bus_err_hold", {31'd0, bus_err}, 32'd1);
        chk("to_instret", instret, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
